song_reader: RTL

- Playback back-end driven by the player control FSM.
- Consumes play, reset_play and next_song. Walks the selected song's note list in ROM and hands each note to the note player with a new_note/note_done handshake.
- Returns song_done to the control FSM when the end-of-song marker or the last ROM slot is reached.

---
 rtl/music_pkg.sv | 47 ++++
 rtl/song_reader_rom.sv | 27 ++
 rtl/song_reader.sv | 107 ++++++++++
 3 files changed

// File: rtl/music_pkg.sv
// Shared widths, state encoding and ROM image helpers for the song playback back-end.
package music_pkg;

    localparam int NOTE_W    = 6;
    localparam int DUR_W     = 6;
    localparam int ADDR_W    = 5;
    localparam int SONG_W    = 2;
    localparam int ROM_W     = NOTE_W + DUR_W;
    localparam int ROM_AW    = SONG_W + ADDR_W;
    localparam int ROM_DEPTH = 1 << ROM_AW;

    localparam logic [DUR_W-1:0]  END_DUR   = '0;
    localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FETCH = 3'd1;
    localparam logic [2:0] S_ISSUE = 3'd2;
    localparam logic [2:0] S_WAIT  = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    typedef enum logic [2:0] {
        IDLE  = S_IDLE,
        FETCH = S_FETCH,
        ISSUE = S_ISSUE,
        WAIT  = S_WAIT,
        DONE  = S_DONE
    } state_t;

    // Whole ROM flattened into one vector; word k sits at bits [k*ROM_W +: ROM_W] as {note, duration}.
    typedef logic [ROM_DEPTH*ROM_W-1:0] rom_image_t;

    function automatic logic [ROM_W-1:0] romWord(input logic [NOTE_W-1:0] n,
                                                 input logic [DUR_W-1:0] d);
        return {n, d};
    endfunction

    function automatic rom_image_t demoImage();
        rom_image_t img;
        img = '0;
        img[0*ROM_W +: ROM_W] = romWord(6'd12, 6'd4);
        img[1*ROM_W +: ROM_W] = romWord(6'd14, 6'd4);
        img[2*ROM_W +: ROM_W] = romWord(6'd16, 6'd8);
        img[3*ROM_W +: ROM_W] = romWord(6'd0, END_DUR);
        return img;
    endfunction

endpackage

// File: rtl/song_reader_rom.sv
// Song note ROM: one registered read per enabled cycle, contents fixed by the INIT image.
module song_rom
    import music_pkg::*;
#(
    parameter rom_image_t INIT = demoImage()
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rd_en_i,
    input  logic [ROM_AW-1:0] addr_i,
    output logic [ROM_W-1:0]  data_o
);

    logic [ROM_W-1:0] data_q;

    // Output only updates on enabled reads so the word holds while a note plays.
    always_ff @(posedge clk) begin
        if (reset) begin
            data_q <= '0;
        end else if (rd_en_i) begin
            data_q <= INIT[addr_i*ROM_W +: ROM_W];
        end
    end

    assign data_o = data_q;

endmodule

// File: rtl/song_reader.sv
// Walks the selected song in ROM and hands notes to the note player via new_note/note_done.
// Build option SONG_READER_LOOP_EN: songs restart from note 0 instead of finishing.
module song_reader
    import music_pkg::*;
#(
    parameter rom_image_t ROM_INIT = demoImage()
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              play,
    input  logic              reset_play,
    input  logic              next_song,
    input  logic              note_done,
    output logic              song_done,
    output logic              new_note,
    output logic [NOTE_W-1:0] note,
    output logic [DUR_W-1:0]  duration,
    output logic [SONG_W-1:0] song_sel
);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [SONG_W-1:0] song_sel_q, song_sel_d;
    logic [ROM_W-1:0]  rom_data;
    logic              isEnd;

    song_rom #(
        .INIT(ROM_INIT)
    ) u_rom (
        .clk    (clk),
        .reset  (reset),
        .rd_en_i(state_q == FETCH),
        .addr_i ({song_sel_q, addr_q}),
        .data_o (rom_data)
    );

    assign {note, duration} = rom_data;
    assign isEnd            = (duration == END_DUR);

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        song_sel_d = next_song ? song_sel_q + 1'b1 : song_sel_q;
        if (reset_play) begin
            state_d = IDLE;
            addr_d  = '0;
        end else begin
            case (state_q)
                IDLE:  if (play) state_d = FETCH;
                FETCH: if (play) state_d = ISSUE;
                ISSUE: begin
                    if (isEnd) begin
`ifdef SONG_READER_LOOP_EN
                        addr_d  = '0;
                        state_d = FETCH;
`else
                        state_d = DONE;
`endif
                    end else begin
                        state_d = WAIT;
                    end
                end
                // The note player pauses itself, so note_done is accepted regardless of play.
                WAIT: begin
                    if (note_done) begin
                        if (addr_q == LAST_ADDR) begin
`ifdef SONG_READER_LOOP_EN
                            addr_d  = '0;
                            state_d = FETCH;
`else
                            state_d = DONE;
`endif
                        end else begin
                            addr_d  = addr_q + 1'b1;
                            state_d = FETCH;
                        end
                    end
                end
                DONE:    state_d = DONE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            song_sel_q <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            song_sel_q <= song_sel_d;
        end
    end

    // ROM data only becomes valid in ISSUE, so the pulse is decoded from state and data registers.
    assign new_note = (state_q == ISSUE) && !isEnd && !reset_play && !reset;
    assign song_sel = song_sel_q;

`ifdef SONG_READER_LOOP_EN
    assign song_done = 1'b0;
`else
    assign song_done = (state_q == DONE);
`endif

endmodule
